// File: rtl/vec_mac_pkg.sv
// Shared definitions for the vector multiply-accumulate block.
// Mode encodings plus the saturating-add and round/shift/saturate helpers.
// Helpers work on 64-bit signed values so one implementation serves any lane width.
package vec_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_res_t;

    // Signed add clamped to a bw-bit signed range; operands are already bw-bit values,
    // so the 64-bit sum itself can never wrap.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 bw);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        sat_res_t           res;
        s       = a + b;
        mx      = (64'sd1 <<< (bw - 1)) - 64'sd1;
        mn      = -mx - 64'sd1;
        res.val = s;
        res.sat = 1'b0;
        if (s > mx) begin
            res.val = mx;
            res.sat = 1'b1;
        end else if (s < mn) begin
            res.val = mn;
            res.sat = 1'b1;
        end
        return res;
    endfunction

    // Round half up, arithmetic shift right, then clamp to a bw-bit signed range.
    function automatic sat_res_t round_sat(input logic signed [63:0] v,
                                           input int                 shift,
                                           input int                 bw);
        logic signed [63:0] r;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        sat_res_t           res;
        r = v;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
            r = r >>> shift;
        end
        mx      = (64'sd1 <<< (bw - 1)) - 64'sd1;
        mn      = -mx - 64'sd1;
        res.val = r;
        res.sat = 1'b0;
        if (r > mx) begin
            res.val = mx;
            res.sat = 1'b1;
        end else if (r < mn) begin
            res.val = mn;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vec_mac_lane.sv
// One lane: S1 product register, S2 frame accumulator and formatted output register.
// Latency: product 1 cycle after prod_en_i, output 1 cycle after out_ld_i.
// Backpressure: none locally; all enables come from the top-level handshake control.
// Ports: a_i/b_i lane operands; prod_en_i loads S1; acc_upd_i / out_ld_i advance S1 into
//        the accumulator or the output register; mode_acc_i/first_i describe the S1 beat.
module vec_mac_lane
    import vec_mac_pkg::*;
#(
    parameter int BW_I   = 8,
    parameter int BW_O   = 16,
    parameter int BW_ACC = 24,
    parameter int SHIFT  = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [BW_I-1:0] a_i,
    input  logic [BW_I-1:0] b_i,
    input  logic            prod_en_i,
    input  logic            acc_upd_i,
    input  logic            out_ld_i,
    input  logic            mode_acc_i,
    input  logic            first_i,
    output logic [BW_O-1:0] data_o,
    output logic            sat_o
);

    localparam int PW = 2 * BW_I;

    logic signed [PW-1:0]     prod_q, prod_d;
    logic signed [BW_ACC-1:0] acc_q, acc_d;
    logic                     acc_sat_q, acc_sat_d;
    logic [BW_O-1:0]          res_q, res_d;
    logic                     res_sat_q, res_sat_d;

    logic signed [63:0]       prod_w;
    logic signed [63:0]       out_w;
    sat_res_t                 sum;
    sat_res_t                 fmt;
    logic                     frame_sat;

    always_comb begin
        prod_d = prod_q;
        if (prod_en_i) begin
            prod_d = PW'($signed(a_i)) * PW'($signed(b_i));
        end

        prod_w = 64'(prod_q);

        // First beat of a frame loads the product instead of adding to stale state.
        if (first_i) begin
            sum.val = prod_w;
            sum.sat = 1'b0;
        end else begin
            sum = sat_add(64'(acc_q), prod_w, BW_ACC);
        end
        // Sticky per-frame flag: any clamp during the frame marks the lane.
        frame_sat = sum.sat | (~first_i & acc_sat_q);

        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        if (acc_upd_i) begin
            acc_d     = sum.val[BW_ACC-1:0];
            acc_sat_d = frame_sat;
        end

        out_w = mode_acc_i ? sum.val : prod_w;
        fmt   = round_sat(out_w, SHIFT, BW_O);

        res_d     = res_q;
        res_sat_d = res_sat_q;
        if (out_ld_i) begin
            res_d     = fmt.val[BW_O-1:0];
            res_sat_d = fmt.sat | (mode_acc_i & frame_sat);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q    <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
        end
    end

    assign data_o = res_q;
    assign sat_o  = res_sat_q;

endmodule

// File: rtl/vec_mac.sv
// Lane-wise signed vector multiply with optional per-frame accumulation and output formatting.
// Latency: 2 cycles fire-to-valid_o (MUL beat or ACC last beat), 1 beat/cycle throughput.
// Backpressure: ready_i low holds the output register; S1 then fills and in_rdy drops.
// Ports: data1_i/data2_i joined A/B streams with valid/last/ready; mode_i picks MUL or ACC
//        per frame; data_o/sat_o/last_o/valid_o with ready_i form the result stream.
module vec_mac
    import vec_mac_pkg::*;
#(
    parameter int BW_I       = 8,
    parameter int BW_O       = 16,
    parameter int BW_ACC     = 24,
    parameter int VECTOR_LEN = 13,
    parameter int SHIFT      = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [VECTOR_LEN*BW_I-1:0] data1_i,
    input  logic                       valid1_i,
    input  logic                       last1_i,
    output logic                       ready1_o,
    input  logic [VECTOR_LEN*BW_I-1:0] data2_i,
    input  logic                       valid2_i,
    input  logic                       last2_i,
    output logic                       ready2_o,
    input  logic                       mode_i,
    output logic [VECTOR_LEN*BW_O-1:0] data_o,
    output logic [VECTOR_LEN-1:0]      sat_o,
    output logic                       valid_o,
    output logic                       last_o,
    input  logic                       ready_i
);

    // S1 beat descriptor
    logic s1_vld_q, s1_vld_d;
    logic s1_last_q, s1_last_d;
    logic s1_mode_q, s1_mode_d;
    logic s1_first_q, s1_first_d;
    // S2 output register state
    logic out_vld_q, out_vld_d;
    logic out_last_q, out_last_d;
    // Frame tracking on the input side
    logic mode_q, mode_d;
    logic first_q, first_d;

    logic out_free;
    logic s1_adv;
    logic in_rdy;
    logic fire;
    logic beat_last;
    logic beat_mode;
    logic out_ld;
    logic acc_upd;

    always_comb begin
        out_free  = ~out_vld_q | ready_i;
        // An ACC non-last beat only touches the accumulator, so it may retire even
        // while the previous frame's result is still waiting downstream.
        s1_adv    = s1_vld_q & (((s1_mode_q == MODE_ACC) & ~s1_last_q) | out_free);
        in_rdy    = ~s1_vld_q | s1_adv;
        fire      = valid1_i & valid2_i & in_rdy;
        beat_last = last1_i | last2_i;
        beat_mode = first_q ? mode_i : mode_q;

        out_ld    = s1_adv & ((s1_mode_q == MODE_MUL) | s1_last_q);
        acc_upd   = s1_adv & (s1_mode_q == MODE_ACC) & ~s1_last_q;

        s1_vld_d   = fire | (s1_vld_q & ~s1_adv);
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        s1_first_d = s1_first_q;
        if (fire) begin
            s1_last_d  = beat_last;
            s1_mode_d  = beat_mode;
            s1_first_d = first_q;
        end

        out_vld_d  = out_ld | (out_vld_q & ~ready_i);
        out_last_d = out_ld ? s1_last_q : out_last_q;

        mode_d  = (fire & first_q) ? mode_i : mode_q;
        first_d = fire ? beat_last : first_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= MODE_MUL;
            s1_first_q <= 1'b1;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            mode_q     <= MODE_MUL;
            first_q    <= 1'b1;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s1_first_q <= s1_first_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            mode_q     <= mode_d;
            first_q    <= first_d;
        end
    end

    for (genvar i = 0; i < VECTOR_LEN; i++) begin : g_lane
        vec_mac_lane #(
            .BW_I  (BW_I),
            .BW_O  (BW_O),
            .BW_ACC(BW_ACC),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .a_i       (data1_i[i*BW_I +: BW_I]),
            .b_i       (data2_i[i*BW_I +: BW_I]),
            .prod_en_i (fire),
            .acc_upd_i (acc_upd),
            .out_ld_i  (out_ld),
            .mode_acc_i(s1_mode_q),
            .first_i   (s1_first_q),
            .data_o    (data_o[i*BW_O +: BW_O]),
            .sat_o     (sat_o[i])
        );
    end

    assign ready1_o = in_rdy;
    assign ready2_o = in_rdy;
    assign valid_o  = out_vld_q;
    assign last_o   = out_last_q;

endmodule

// File: tb/tb_vec_mac.sv
module tb_vec_mac;
    import vec_mac_pkg::*;

    localparam int VL = 13;
    localparam int BI = 8;
    localparam int BO = 16;

    typedef struct {
        logic [VL*BO-1:0] d;
        logic [VL-1:0]    s;
        logic             l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [VL*BI-1:0] d1, d2;
    logic             v1, v2, l1, l2, mode, rdy;
    logic             r1, r2, vo, lo;
    logic [VL*BO-1:0] dout;
    logic [VL-1:0]    sat;
    // second instance built with SHIFT = 2, sharing data/last/mode
    logic             v1s, v2s, rdys;
    logic             r1s, r2s, vos, los;
    logic [VL*BO-1:0] douts;
    logic [VL-1:0]    sats;

    exp_t q[$];
    exp_t qs[$];
    exp_t me, mes;
    int   vectors = 0;
    int   miscompares = 0;

    vec_mac #(.BW_I(BI), .BW_O(BO), .BW_ACC(24), .VECTOR_LEN(VL), .SHIFT(0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .data1_i(d1), .valid1_i(v1), .last1_i(l1), .ready1_o(r1),
        .data2_i(d2), .valid2_i(v2), .last2_i(l2), .ready2_o(r2),
        .mode_i(mode), .data_o(dout), .sat_o(sat), .valid_o(vo), .last_o(lo), .ready_i(rdy)
    );

    vec_mac #(.BW_I(BI), .BW_O(BO), .BW_ACC(24), .VECTOR_LEN(VL), .SHIFT(2)) u_dut_s2 (
        .clk_i(clk), .rst_i(rst),
        .data1_i(d1), .valid1_i(v1s), .last1_i(l1), .ready1_o(r1s),
        .data2_i(d2), .valid2_i(v2s), .last2_i(l2), .ready2_o(r2s),
        .mode_i(mode), .data_o(douts), .sat_o(sats), .valid_o(vos), .last_o(los), .ready_i(rdys)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [VL*BO-1:0] mk(input int x0, input int x1);
        logic [VL*BO-1:0] v;
        v = '0;
        v[BO-1:0]    = BO'(x0);
        v[2*BO-1:BO] = BO'(x1);
        return v;
    endfunction

    task automatic push(input bit sh, input int x0, input int x1,
                        input logic [VL-1:0] s, input logic l);
        exp_t e;
        e.d = mk(x0, x1);
        e.s = s;
        e.l = l;
        if (sh) qs.push_back(e);
        else    q.push_back(e);
    endtask

    // Drive one beat (lanes 0/1 only) and hold it until the DUT takes it.
    task automatic send(input bit sh, input int a0, input int b0, input int a1, input int b1,
                        input logic [1:0] lst, input logic md);
        int n;
        d1 = '0;
        d2 = '0;
        d1[BI-1:0]    = BI'(a0);
        d1[2*BI-1:BI] = BI'(a1);
        d2[BI-1:0]    = BI'(b0);
        d2[2*BI-1:BI] = BI'(b1);
        l1   = lst[0];
        l2   = lst[1];
        mode = md;
        if (sh) begin v1s = 1'b1; v2s = 1'b1; end
        else    begin v1  = 1'b1; v2  = 1'b1; end
        n = 0;
        @(negedge clk);
        while (!(sh ? r1s : r1) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: input ready never rose, expected acceptance within 200 cycles");
        end
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0; v1s = 1'b0; v2s = 1'b0;
        l1 = 1'b0; l2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || qs.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q.size(), qs.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors
    logic             held;
    logic [VL*BO-1:0] held_d;
    logic [VL-1:0]    held_s;
    logic             held_l;
    initial held = 1'b0;

    always @(negedge clk) begin
        if (vo && rdy) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got data %0h last %0b, expected no output", dout, lo);
            end else begin
                me = q.pop_front();
                chk("out_data", 256'(dout), 256'(me.d));
                chk("out_sat", 256'(sat), 256'(me.s));
                chk("out_last", 256'(lo), 256'(me.l));
            end
        end
        if (vo && !rdy) begin
            if (held) begin
                chk("stall_data", 256'(dout), 256'(held_d));
                chk("stall_sat", 256'(sat), 256'(held_s));
                chk("stall_last", 256'(lo), 256'(held_l));
            end
            held   = 1'b1;
            held_d = dout;
            held_s = sat;
            held_l = lo;
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (vos && rdys) begin
            if (qs.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output_shift: got data %0h, expected no output", douts);
            end else begin
                mes = qs.pop_front();
                chk("shift_data", 256'(douts), 256'(mes.d));
                chk("shift_sat", 256'(sats), 256'(mes.s));
                chk("shift_last", 256'(los), 256'(mes.l));
            end
        end
    end

    logic saw_low;

    initial begin
        rst = 1'b1;
        d1 = '0; d2 = '0;
        v1 = 1'b0; v2 = 1'b0; v1s = 1'b0; v2s = 1'b0;
        l1 = 1'b0; l2 = 1'b0; mode = MODE_MUL;
        rdy = 1'b1; rdys = 1'b1;
        saw_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid", 256'(vo), 256'(1'b0));
        chk("rst_data", 256'(dout), 256'(0));
        chk("rst_last", 256'(lo), 256'(1'b0));
        chk("rst_ready", 256'(r1), 256'(1'b1));

        // MUL mode with 2-cycle latency, last_o follows input
        push(0, -12, 16129, '0, 1'b0);
        send(0, 3, -4, 127, 127, 2'b00, MODE_MUL);
        chk("lat_fire_edge", 256'(vo), 256'(1'b0));
        @(posedge clk);
        #1;
        chk("lat_second_edge", 256'(vo), 256'(1'b1));
        push(0, 1, 2, '0, 1'b1);
        send(0, 1, 1, 1, 2, 2'b01, MODE_MUL);
        drain();

        // ACC 3-beat frame: 100 - 20 + 6 = 86; lane1 1+1+1 = 3; mid-frame mode change ignored
        push(0, 86, 3, '0, 1'b1);
        send(0, 10, 10, 1, 1, 2'b00, MODE_ACC);
        send(0, -5, 4, 1, 1, 2'b00, MODE_MUL);
        send(0, 2, 3, 1, 1, 2'b10, MODE_ACC);
        drain();

        // ACC saturation: 4 * 16384 = 65536 clamps to 32767
        push(0, 32767, 0, 13'h0001, 1'b1);
        for (int k = 0; k < 4; k++) send(0, -128, -128, 0, 0, (k == 3) ? 2'b01 : 2'b00, MODE_ACC);
        drain();

        // Backpressure: 5 MUL beats, ready_i low 3 cycles mid-stream
        for (int k = 1; k <= 5; k++) push(0, k, 2 * k, '0, (k == 5));
        fork
            begin
                for (int k = 1; k <= 5; k++) send(0, k, 1, k, 2, (k == 5) ? 2'b01 : 2'b00, MODE_MUL);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!r1 && !r2) saw_low = 1'b1;
                end
                @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join
        chk("bp_in_ready_low", 256'(saw_low), 256'(1'b1));
        drain();

        // Join: lone valid1 consumes nothing
        d1 = '0; d2 = '0;
        d1[BI-1:0] = 8'd5;
        d2[BI-1:0] = 8'd5;
        l1 = 1'b1; mode = MODE_MUL;
        v1 = 1'b1; v2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("join_no_output", 256'(vo), 256'(1'b0));
        push(0, 25, 0, '0, 1'b1);
        v2 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0; l1 = 1'b0;
        drain();

        // SHIFT = 2 rounding: 7 -> 2, 6 -> 2, -6 -> -1
        push(1, 2, 0, '0, 1'b1);
        send(1, 7, 1, 0, 0, 2'b01, MODE_MUL);
        push(1, 2, 0, '0, 1'b1);
        send(1, 6, 1, 0, 0, 2'b01, MODE_MUL);
        push(1, -1, 0, '0, 1'b1);
        send(1, -6, 1, 0, 0, 2'b01, MODE_MUL);
        drain();

        // Reset mid-frame discards the partial accumulation
        send(0, 4, 4, 1, 1, 2'b00, MODE_ACC);
        send(0, 5, 5, 0, 0, 2'b00, MODE_ACC);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 256'(vo), 256'(1'b0));
        chk("async_rst_data", 256'(dout), 256'(0));
        chk("async_rst_sat", 256'(sat), 256'(0));
        chk("async_rst_last", 256'(lo), 256'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(0, 6, 0, '0, 1'b1);
        send(0, 2, 3, 0, 0, 2'b01, MODE_ACC);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vec_mac.md
Name: vec_mac

Overview:
Parametrised, fully handshaked vector multiply-accumulate for the word-detect datapath.
- Joins two signed vector streams and multiplies lane-wise.
- Either emits every product vector, or accumulates products across a frame (terminated by last) and emits one result per frame.
- Output is rounded, shifted and saturated to BW_O, with per-lane saturation flags.
- Sits between feature/weight sources and the downstream adder/argmax stages.

Parameters:
BW_I, 8, signed input element width
BW_O, 16, signed output element width
BW_ACC, 24, signed accumulator width (must be >= 2*BW_I)
VECTOR_LEN, 13, number of lanes
SHIFT, 0, arithmetic right shift applied before output saturation

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
data1_i  in  VECTOR_LEN*BW_I  signed vector A, lane i at [(i+1)*BW_I-1 : i*BW_I]
valid1_i  in  1  A valid
last1_i  in  1  A end of frame
ready1_o  out  1  A ready
data2_i  in  VECTOR_LEN*BW_I  signed vector B, same packing
valid2_i  in  1  B valid
last2_i  in  1  B end of frame
ready2_o  out  1  B ready
mode_i  in  1  0 = MUL (per-beat output), 1 = ACC (per-frame output)
data_o  out  VECTOR_LEN*BW_O  signed result, same packing
sat_o  out  VECTOR_LEN  per-lane saturation flag for the current data_o
valid_o  out  1  result valid
last_o  out  1  result end of frame
ready_i  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release): all valids 0; data_o, sat_o, last_o 0; accumulators 0; first-beat flag 1. Reset mid-frame discards the partial accumulation.
- Join and fire:
  - ready1_o = ready2_o = in_rdy.
  - in_rdy depends only on internal occupancy and ready_i, never on valid1_i/valid2_i.
  - fire = valid1_i & valid2_i & in_rdy.
  - A single valid consumes nothing.
- Frame end: beat_last = last1_i | last2_i.
- Mode capture: mode_i is sampled on the first beat of a frame and held until the beat_last beat. Changes mid-frame are ignored.
- Pipeline:
  - S1 registers the lane products (2*BW_I, signed).
  - S2 holds the per-lane accumulator and the output register.
  - Each stage advances when it is empty or its content is being consumed. Throughput is 1 beat/cycle.
  - Latency: fire to valid_o = 2 cycles with ready_i high.
- MUL mode: every beat produces an output. last_o = beat_last of that beat.
- ACC mode:
  - On the first beat, acc = product (load, not add). Otherwise acc = acc + product, saturating at the BW_ACC signed bounds.
  - Non-last beats produce no output.
  - The beat_last beat writes the output register with acc + product, sets last_o = 1, and re-arms the first-beat flag.
  - A single-beat frame outputs its product.
  - A non-last beat may update acc while a previous frame's result waits in the output register. A last beat stalls until the output register is free or consumed this cycle.
- Output formatting:
  - If SHIFT > 0, add 1<<(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [-2^(BW_O-1), 2^(BW_O-1)-1].
  - sat_o[i] = 1 if lane i saturated in output formatting or in any accumulation of that frame.
- Backpressure: while valid_o & !ready_i, data_o, sat_o and last_o hold stable. With both stages full, in_rdy = 0. No beat is lost, duplicated or reordered.

Decomposition:
- Package vec_mac_pkg holds:
  - mode constants MODE_MUL = 1'b0, MODE_ACC = 1'b1;
  - functions sat_add (saturating signed add to BW_ACC) and round_sat (round, shift, saturate to BW_O, returns value plus flag).
- Sub-module vec_mac_lane: one lane's product register, accumulator and formatter. Instantiated VECTOR_LEN times by generate.
- The top level holds the handshake, stage valids, mode and first-beat control.

Test Plan:
(defaults unless stated)
- MUL mode, lane0 = 3 * -4, lane1 = 127 * 127, ready_i = 1 -> valid_o 2 cycles after fire; lane0 = -12, lane1 = 16129, sat_o = 0, last_o follows input.
- ACC mode, 3-beat frame, lane0 = 10*10, -5*4, 2*3, last on beat 3 -> exactly one valid_o; lane0 = 86, last_o = 1; no valid_o on beats 1-2.
- Saturation:
  - ACC mode, 4 beats of -128 * -128 -> lane0 = 32767, sat_o[0] = 1.
  - SHIFT = 2 build, MUL mode: 7*1 -> 2, 6*1 -> 2, -6*1 -> -1.
- Backpressure: 5 MUL beats back-to-back, ready_i low 3 cycles mid-stream -> data_o stable while stalled; ready1_o/ready2_o low once both stages full; 5 outputs in order, none lost or duplicated.
- Join: valid1_i high, valid2_i low for 4 cycles -> no fire, no output. Then valid2_i high for one cycle -> exactly one output.
- Reset mid-frame: ACC mode, 2 non-last beats, pulse rst_i asynchronously (outputs 0 immediately), then single-beat frame 2*3 with last -> output 6 (partial sum discarded).
